hazard_ctrl_seq: RTL and testbench

Parametrised successor to the pipeline hazard unit. It sits beside the ID stage and decides stall, bubble, flush and freeze for the whole pipeline. Over the previous generation it adds:
- a configurable register-address width;
- a full-pipeline freeze for multi-cycle data memory;
- an ID-stage jump-operand stall when forwarding is enabled;
- a stall-watchdog state machine;
- saturating performance counters.

---
 rtl/hazard_ctrl_seq_if.sv | 55 +++++
 rtl/hazard_ctrl_seq.sv | 120 ++++++++++++
 tb/tb_hazard_ctrl_seq.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_seq_if.sv
// rtl/hazard_ctrl_seq_if.sv - pipeline stage status in, stall/flush/freeze decisions and counters out
interface hazard_ctrl_seq_if #(
    parameter int REG_W = 2,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic             use_rs;
    logic             use_rt;
    logic             use_rs_at_id;
    logic [REG_W-1:0] rs_id;
    logic [REG_W-1:0] rt_id;
    logic             reg_write_ex;
    logic             reg_write_mem;
    logic             reg_write_wb;
    logic [REG_W-1:0] write_reg_ex;
    logic [REG_W-1:0] write_reg_mem;
    logic [REG_W-1:0] write_reg_wb;
    logic             d_mem_read_ex;
    logic             d_mem_read_mem;
    logic             d_mem_read_wb;
    logic             jump_miss;
    logic             branch_miss;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_write;
    logic             ir_write;
    logic             bubblify;
    logic             flush_if;
    logic             pipe_freeze;
    logic             incr_num_inst;
    logic [CNT_W-1:0] num_inst;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
    logic             stall_timeout;

    modport master (
        output id_valid, use_rs, use_rt, use_rs_at_id, rs_id, rt_id,
               reg_write_ex, reg_write_mem, reg_write_wb,
               write_reg_ex, write_reg_mem, write_reg_wb,
               d_mem_read_ex, d_mem_read_mem, d_mem_read_wb,
               jump_miss, branch_miss, mem_req, mem_ready,
        input  pc_write, ir_write, bubblify, flush_if, pipe_freeze, incr_num_inst,
               num_inst, stall_cycles, flush_count, stall_timeout
    );

    modport slave (
        input  id_valid, use_rs, use_rt, use_rs_at_id, rs_id, rt_id,
               reg_write_ex, reg_write_mem, reg_write_wb,
               write_reg_ex, write_reg_mem, write_reg_wb,
               d_mem_read_ex, d_mem_read_mem, d_mem_read_wb,
               jump_miss, branch_miss, mem_req, mem_ready,
        output pc_write, ir_write, bubblify, flush_if, pipe_freeze, incr_num_inst,
               num_inst, stall_cycles, flush_count, stall_timeout
    );
endinterface

// File: rtl/hazard_ctrl_seq.sv
// rtl/hazard_ctrl_seq.sv - hazard unit: freeze/stall/flush decision, stall watchdog, saturating counters
module hazard_ctrl_seq #(
    parameter int REG_W              = 2,
    parameter int DATA_FORWARDING    = 1,
    parameter int RF_SELF_FORWARDING = 1,
    parameter int CNT_W              = 16,
    parameter int MAX_STALL          = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    hazard_ctrl_seq_if.slave bus
);
    typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FREEZE} state_e;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_STALL);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] consec_q, consec_d;
    logic [CNT_W-1:0] num_inst_q, num_inst_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             stall_timeout_q, stall_timeout_d;

    logic m_ex_rs, m_ex_rt, m_mem_rs, m_mem_rt, m_wb_rs, m_wb_rt;
    logic load_use, fwd_stall, wb_stall, data_stall, freeze;
    logic pc_write, ir_write, bubblify, flush_if, pipe_freeze, incr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        m_ex_rs  = bus.reg_write_ex  && (bus.write_reg_ex  == bus.rs_id);
        m_ex_rt  = bus.reg_write_ex  && (bus.write_reg_ex  == bus.rt_id);
        m_mem_rs = bus.reg_write_mem && (bus.write_reg_mem == bus.rs_id);
        m_mem_rt = bus.reg_write_mem && (bus.write_reg_mem == bus.rt_id);
        m_wb_rs  = bus.reg_write_wb  && (bus.write_reg_wb  == bus.rs_id);
        m_wb_rt  = bus.reg_write_wb  && (bus.write_reg_wb  == bus.rt_id);

        load_use = bus.d_mem_read_ex && ((bus.use_rs && m_ex_rs) || (bus.use_rt && m_ex_rt));
        if (DATA_FORWARDING == 0) begin
            fwd_stall = (bus.use_rs && (m_ex_rs || m_mem_rs)) ||
                        (bus.use_rt && (m_ex_rt || m_mem_rt));
        end else begin
            // Jump targets are read in ID, ahead of the EX bypass point
            fwd_stall = bus.use_rs_at_id && (m_ex_rs || (bus.d_mem_read_mem && m_mem_rs));
        end
        wb_stall   = (RF_SELF_FORWARDING == 0) &&
                     ((bus.use_rs && m_wb_rs) || (bus.use_rt && m_wb_rt));
        data_stall = bus.id_valid && (load_use || fwd_stall || wb_stall);
        freeze     = bus.mem_req && !bus.mem_ready;
    end

    always_comb begin
        pc_write    = 1'b1;
        ir_write    = 1'b1;
        bubblify    = 1'b0;
        flush_if    = 1'b0;
        pipe_freeze = 1'b0;
        if (!reset_n) begin
            pc_write = 1'b0;
            ir_write = 1'b0;
            bubblify = 1'b1;
        end else if (freeze) begin
            pc_write    = 1'b0;
            ir_write    = 1'b0;
            pipe_freeze = 1'b1;
        end else if (data_stall) begin
            pc_write = 1'b0;
            ir_write = 1'b0;
            bubblify = 1'b1;
        end else begin
            flush_if = bus.jump_miss || bus.branch_miss;
            bubblify = bus.branch_miss;
        end
        incr = reset_n && bus.id_valid && !bubblify && !flush_if && !pipe_freeze;
    end

    always_comb begin
        state_d = freeze ? ST_FREEZE : (data_stall ? ST_STALL : ST_RUN);
        // consec is zero whenever the FSM sits in RUN, so a fresh run starts at one
        if (state_d == ST_RUN)      consec_d = '0;
        else if (state_q == ST_RUN) consec_d = CNT_W'(1);
        else if (consec_q < MAX_C)  consec_d = consec_q + 1'b1;
        else                        consec_d = consec_q;
        stall_timeout_d = stall_timeout_q || (consec_d >= MAX_C);
        num_inst_d      = incr ? sat_inc(num_inst_q) : num_inst_q;
        stall_cycles_d  = (freeze || data_stall) ? sat_inc(stall_cycles_q) : stall_cycles_q;
        flush_count_d   = flush_if ? sat_inc(flush_count_q) : flush_count_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= ST_RUN;
            consec_q        <= '0;
            num_inst_q      <= '0;
            stall_cycles_q  <= '0;
            flush_count_q   <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            consec_q        <= consec_d;
            num_inst_q      <= num_inst_d;
            stall_cycles_q  <= stall_cycles_d;
            flush_count_q   <= flush_count_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

    assign bus.pc_write      = pc_write;
    assign bus.ir_write      = ir_write;
    assign bus.bubblify      = bubblify;
    assign bus.flush_if      = flush_if;
    assign bus.pipe_freeze   = pipe_freeze;
    assign bus.incr_num_inst = incr;
    assign bus.num_inst      = num_inst_q;
    assign bus.stall_cycles  = stall_cycles_q;
    assign bus.flush_count   = flush_count_q;
    assign bus.stall_timeout = stall_timeout_q;
endmodule

// File: tb/tb_hazard_ctrl_seq.sv
// tb/tb_hazard_ctrl_seq.sv - three configurations checked against vector table, directed sequences and a model
module tb_hazard_ctrl_seq;
    typedef struct {
        bit       id_valid, use_rs, use_rt, use_rs_at_id;
        logic [3:0] rs, rt, wr_ex, wr_mem, wr_wb;
        bit       rw_ex, rw_mem, rw_wb, ld_ex, ld_mem, ld_wb;
        bit       jm, bm, mreq, mrdy;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [5:0] exp_a;
        logic [5:0] exp_b;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_seq_if #(.REG_W(2), .CNT_W(4))  ifa();
    hazard_ctrl_seq_if #(.REG_W(2), .CNT_W(16)) ifb();
    hazard_ctrl_seq_if #(.REG_W(4), .CNT_W(16)) ifc();

    hazard_ctrl_seq #(.REG_W(2), .DATA_FORWARDING(1), .RF_SELF_FORWARDING(1), .CNT_W(4), .MAX_STALL(4))
        dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
    hazard_ctrl_seq #(.REG_W(2), .DATA_FORWARDING(0), .RF_SELF_FORWARDING(0), .CNT_W(16), .MAX_STALL(64))
        dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));
    hazard_ctrl_seq #(.REG_W(4), .DATA_FORWARDING(1), .RF_SELF_FORWARDING(0), .CNT_W(16), .MAX_STALL(64))
        dut_c (.clk(clk), .reset_n(reset_n), .bus(ifc));

    int rw[3]     = '{2, 2, 4};
    int df[3]     = '{1, 0, 1};
    int rsf[3]    = '{1, 0, 0};
    int cmax[3]   = '{15, 65535, 65535};
    int maxst[3]  = '{4, 64, 64};
    int m_num[3], m_stl[3], m_fl[3], m_consec[3], m_to[3];
    int checks = 0;
    int passes = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        s.id_valid = 1'b1;
        return s;
    endfunction

    // Decision bits {pc_write, ir_write, bubblify, flush_if, pipe_freeze, incr}; kind 0=run 1=stall 2=freeze
    function automatic logic [5:0] mdl_comb(int k, stim_t s, bit rst, output int kind);
        int  m  = 1 << rw[k];
        int  rs = int'(s.rs) % m;
        int  rt = int'(s.rt) % m;
        bit  ex_rs  = s.rw_ex  && (int'(s.wr_ex)  % m == rs);
        bit  ex_rt  = s.rw_ex  && (int'(s.wr_ex)  % m == rt);
        bit  mem_rs = s.rw_mem && (int'(s.wr_mem) % m == rs);
        bit  mem_rt = s.rw_mem && (int'(s.wr_mem) % m == rt);
        bit  wb_rs  = s.rw_wb  && (int'(s.wr_wb)  % m == rs);
        bit  wb_rt  = s.rw_wb  && (int'(s.wr_wb)  % m == rt);
        bit  stall = 0;
        kind = 0;
        if (rst) return 6'b001000;
        if (s.mreq && !s.mrdy) begin
            kind = 2;
            return 6'b000010;
        end
        if (s.ld_ex && ((s.use_rs && ex_rs) || (s.use_rt && ex_rt))) stall = 1;
        if (df[k] == 0 && ((s.use_rs && (ex_rs || mem_rs)) || (s.use_rt && (ex_rt || mem_rt)))) stall = 1;
        if (df[k] == 1 && s.use_rs_at_id && (ex_rs || (s.ld_mem && mem_rs))) stall = 1;
        if (rsf[k] == 0 && ((s.use_rs && wb_rs) || (s.use_rt && wb_rt))) stall = 1;
        if (s.id_valid && stall) begin
            kind = 1;
            return 6'b001000;
        end
        return {1'b1, 1'b1, s.bm, s.jm || s.bm, 1'b0, s.id_valid && !s.jm && !s.bm};
    endfunction

    task automatic mdl_clock(stim_t s, bit rst);
        logic [5:0] d;
        int kind;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_num[k] = 0; m_stl[k] = 0; m_fl[k] = 0; m_consec[k] = 0; m_to[k] = 0;
            end else begin
                d = mdl_comb(k, s, 1'b0, kind);
                if (d[0] && m_num[k] < cmax[k]) m_num[k]++;
                if (d[2] && m_fl[k] < cmax[k]) m_fl[k]++;
                if (kind != 0 && m_stl[k] < cmax[k]) m_stl[k]++;
                m_consec[k] = (kind != 0) ? m_consec[k] + 1 : 0;
                if (m_consec[k] >= maxst[k]) m_to[k] = 1;
            end
        end
    endtask

    task automatic drive_one(int k, stim_t s);
        case (k)
            0: begin
                ifa.id_valid = s.id_valid; ifa.use_rs = s.use_rs; ifa.use_rt = s.use_rt; ifa.use_rs_at_id = s.use_rs_at_id;
                ifa.rs_id = s.rs[1:0]; ifa.rt_id = s.rt[1:0];
                ifa.reg_write_ex = s.rw_ex; ifa.reg_write_mem = s.rw_mem; ifa.reg_write_wb = s.rw_wb;
                ifa.write_reg_ex = s.wr_ex[1:0]; ifa.write_reg_mem = s.wr_mem[1:0]; ifa.write_reg_wb = s.wr_wb[1:0];
                ifa.d_mem_read_ex = s.ld_ex; ifa.d_mem_read_mem = s.ld_mem; ifa.d_mem_read_wb = s.ld_wb;
                ifa.jump_miss = s.jm; ifa.branch_miss = s.bm; ifa.mem_req = s.mreq; ifa.mem_ready = s.mrdy;
            end
            1: begin
                ifb.id_valid = s.id_valid; ifb.use_rs = s.use_rs; ifb.use_rt = s.use_rt; ifb.use_rs_at_id = s.use_rs_at_id;
                ifb.rs_id = s.rs[1:0]; ifb.rt_id = s.rt[1:0];
                ifb.reg_write_ex = s.rw_ex; ifb.reg_write_mem = s.rw_mem; ifb.reg_write_wb = s.rw_wb;
                ifb.write_reg_ex = s.wr_ex[1:0]; ifb.write_reg_mem = s.wr_mem[1:0]; ifb.write_reg_wb = s.wr_wb[1:0];
                ifb.d_mem_read_ex = s.ld_ex; ifb.d_mem_read_mem = s.ld_mem; ifb.d_mem_read_wb = s.ld_wb;
                ifb.jump_miss = s.jm; ifb.branch_miss = s.bm; ifb.mem_req = s.mreq; ifb.mem_ready = s.mrdy;
            end
            default: begin
                ifc.id_valid = s.id_valid; ifc.use_rs = s.use_rs; ifc.use_rt = s.use_rt; ifc.use_rs_at_id = s.use_rs_at_id;
                ifc.rs_id = s.rs; ifc.rt_id = s.rt;
                ifc.reg_write_ex = s.rw_ex; ifc.reg_write_mem = s.rw_mem; ifc.reg_write_wb = s.rw_wb;
                ifc.write_reg_ex = s.wr_ex; ifc.write_reg_mem = s.wr_mem; ifc.write_reg_wb = s.wr_wb;
                ifc.d_mem_read_ex = s.ld_ex; ifc.d_mem_read_mem = s.ld_mem; ifc.d_mem_read_wb = s.ld_wb;
                ifc.jump_miss = s.jm; ifc.branch_miss = s.bm; ifc.mem_req = s.mreq; ifc.mem_ready = s.mrdy;
            end
        endcase
    endtask

    function automatic logic [5:0] get_comb(int k);
        case (k)
            0: return {ifa.pc_write, ifa.ir_write, ifa.bubblify, ifa.flush_if, ifa.pipe_freeze, ifa.incr_num_inst};
            1: return {ifb.pc_write, ifb.ir_write, ifb.bubblify, ifb.flush_if, ifb.pipe_freeze, ifb.incr_num_inst};
            default: return {ifc.pc_write, ifc.ir_write, ifc.bubblify, ifc.flush_if, ifc.pipe_freeze, ifc.incr_num_inst};
        endcase
    endfunction

    function automatic int rd(int k, int w);
        case (k)
            0: case (w) 0: return int'(ifa.num_inst); 1: return int'(ifa.stall_cycles);
                        2: return int'(ifa.flush_count); default: return int'(ifa.stall_timeout); endcase
            1: case (w) 0: return int'(ifb.num_inst); 1: return int'(ifb.stall_cycles);
                        2: return int'(ifb.flush_count); default: return int'(ifb.stall_timeout); endcase
            default: case (w) 0: return int'(ifc.num_inst); 1: return int'(ifc.stall_cycles);
                        2: return int'(ifc.flush_count); default: return int'(ifc.stall_timeout); endcase
        endcase
    endfunction

    // Called at posedge+1; returns at the next posedge+1 with the model advanced
    task automatic step(stim_t s, bit rst, bit use_tab, logic [5:0] ea, logic [5:0] eb);
        int kd;
        for (int k = 0; k < 3; k++) drive_one(k, s);
        reset_n = !rst;
        #2;
        for (int k = 0; k < 3; k++)
            chk($sformatf("comb_dut%0d", k), int'(get_comb(k)), int'(mdl_comb(k, s, rst, kd)));
        if (use_tab) begin
            chk("table_a", int'(get_comb(0)), int'(ea));
            chk("table_b", int'(get_comb(1)), int'(eb));
        end
        @(posedge clk);
        mdl_clock(s, rst);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("num_inst_dut%0d", k),      rd(k, 0), m_num[k]);
            chk($sformatf("stall_cycles_dut%0d", k),  rd(k, 1), m_stl[k]);
            chk($sformatf("flush_count_dut%0d", k),   rd(k, 2), m_fl[k]);
            chk($sformatf("stall_timeout_dut%0d", k), rd(k, 3), m_to[k]);
        end
    endtask

    task automatic run(stim_t s, bit rst);
        step(s, rst, 1'b0, 6'b0, 6'b0);
    endtask

    vec_t  vt[14];
    stim_t s, lu, fz, r;

    initial begin
        for (int i = 0; i < 14; i++) begin
            vt[i].s = idle(); vt[i].exp_a = 6'b110001; vt[i].exp_b = 6'b110001;
        end
        lu = idle(); lu.ld_ex = 1; lu.rw_ex = 1; lu.wr_ex = 4'd2; lu.use_rt = 1; lu.rt = 4'd2;
        vt[1].s = lu;  vt[1].exp_a = 6'b001000; vt[1].exp_b = 6'b001000;
        vt[2].s.rw_mem = 1; vt[2].s.wr_mem = 4'd3; vt[2].s.use_rs = 1; vt[2].s.rs = 4'd3; vt[2].exp_b = 6'b001000;
        vt[3].s.rw_ex = 1; vt[3].s.wr_ex = 4'd1; vt[3].s.use_rs = 1; vt[3].s.use_rs_at_id = 1; vt[3].s.rs = 4'd1;
        vt[3].exp_a = 6'b001000; vt[3].exp_b = 6'b001000;
        vt[4].s.rw_wb = 1; vt[4].s.wr_wb = 4'd2; vt[4].s.use_rt = 1; vt[4].s.rt = 4'd2; vt[4].exp_b = 6'b001000;
        vt[5].s.jm = 1; vt[5].exp_a = 6'b110100; vt[5].exp_b = 6'b110100;
        vt[6].s.bm = 1; vt[6].exp_a = 6'b111100; vt[6].exp_b = 6'b111100;
        vt[7].s.jm = 1; vt[7].s.bm = 1; vt[7].exp_a = 6'b111100; vt[7].exp_b = 6'b111100;
        vt[8].s.mreq = 1; vt[8].s.bm = 1; vt[8].exp_a = 6'b000010; vt[8].exp_b = 6'b000010;
        vt[9].s.mreq = 1; vt[9].s.mrdy = 1;
        vt[10].s = lu; vt[10].s.bm = 1; vt[10].exp_a = 6'b001000; vt[10].exp_b = 6'b001000;
        vt[11].s = lu; vt[11].s.id_valid = 0; vt[11].exp_a = 6'b110000; vt[11].exp_b = 6'b110000;
        vt[12].s.ld_mem = 1; vt[12].s.rw_mem = 1; vt[12].s.wr_mem = 4'd1; vt[12].s.use_rs_at_id = 1;
        vt[12].s.use_rs = 1; vt[12].s.rs = 4'd1; vt[12].exp_a = 6'b001000; vt[12].exp_b = 6'b001000;
        vt[13].s = lu; vt[13].s.wr_ex = 4'd1;

        @(posedge clk); #1;
        run(idle(), 1'b1);
        run(idle(), 1'b1);
        chk("reset_comb_a", int'(get_comb(0)), 6'b001000);
        chk("reset_num_inst", rd(0, 0), 0);
        chk("reset_timeout", rd(0, 3), 0);

        for (int i = 0; i < 14; i++) step(vt[i].s, 1'b0, 1'b1, vt[i].exp_a, vt[i].exp_b);

        run(idle(), 1'b1);
        run(lu, 1'b0);
        chk("lu_ctl", int'(get_comb(0)), 6'b001000);
        chk("lu_stall_cycles", rd(0, 1), 1);
        run(idle(), 1'b0);
        chk("lu_pc_write", int'(ifa.pc_write), 1);
        chk("lu_num_inst", rd(0, 0), 1);

        run(idle(), 1'b1);
        fz = idle(); fz.mreq = 1; fz.bm = 1;
        for (int i = 0; i < 5; i++) begin
            run(fz, 1'b0);
            chk("frz_pipe_freeze", int'(ifb.pipe_freeze), 1);
            chk("frz_flush_if", int'(ifb.flush_if), 0);
        end
        chk("frz_stall_cycles", rd(1, 1), 5);
        fz.mrdy = 1;
        run(fz, 1'b0);
        chk("frz_release_flush", int'(ifb.flush_if), 1);
        chk("frz_release_bubble", int'(ifb.bubblify), 1);
        chk("frz_flush_count", rd(1, 2), 1);

        run(idle(), 1'b1);
        fz = idle(); fz.mreq = 1;
        for (int i = 0; i < 3; i++) run(fz, 1'b0);
        chk("wd_before_trip", rd(0, 3), 0);
        run(fz, 1'b0);
        chk("wd_trip", rd(0, 3), 1);
        for (int i = 0; i < 3; i++) run(idle(), 1'b0);
        chk("wd_sticky", rd(0, 3), 1);
        run(idle(), 1'b1);
        chk("wd_reset_clears", rd(0, 3), 0);

        for (int i = 0; i < 20; i++) run(idle(), 1'b0);
        chk("sat_num_inst_a", rd(0, 0), 15);
        chk("sat_num_inst_b", rd(1, 0), 20);

        for (int i = 0; i < 3; i++) run(lu, 1'b0);
        run(lu, 1'b1);
        chk("midstall_num_inst", rd(0, 0), 0);
        chk("midstall_stall_cycles", rd(1, 1), 0);
        for (int i = 0; i < 3; i++) run(fz, 1'b0);
        chk("midstall_consec_cleared", rd(0, 3), 0);

        s = lu; s.wr_ex = 4'd13; s.rt = 4'd5;
        run(s, 1'b0);
        chk("width_c_no_stall", int'(get_comb(2)), 6'b110001);
        chk("width_a_aliased", int'(get_comb(0)), 6'b001000);

        for (int i = 0; i < 400; i++) begin
            r = '{default: '0};
            r.id_valid = 1'($urandom_range(0, 7) != 0);
            r.use_rs = 1'($urandom); r.use_rt = 1'($urandom); r.use_rs_at_id = 1'($urandom);
            r.rs = 4'($urandom_range(0, 3)) | ($urandom_range(0, 1) ? 4'd12 : 4'd0);
            r.rt = 4'($urandom_range(0, 3)) | ($urandom_range(0, 1) ? 4'd8 : 4'd0);
            r.wr_ex = 4'($urandom_range(0, 3)) | ($urandom_range(0, 1) ? 4'd12 : 4'd0);
            r.wr_mem = 4'($urandom_range(0, 3)) | ($urandom_range(0, 1) ? 4'd8 : 4'd0);
            r.wr_wb = 4'($urandom_range(0, 3)) | ($urandom_range(0, 1) ? 4'd12 : 4'd0);
            r.rw_ex = 1'($urandom); r.rw_mem = 1'($urandom); r.rw_wb = 1'($urandom);
            r.ld_ex = 1'($urandom); r.ld_mem = 1'($urandom); r.ld_wb = 1'($urandom);
            r.jm = ($urandom_range(0, 5) == 0); r.bm = ($urandom_range(0, 5) == 0);
            r.mreq = ($urandom_range(0, 3) == 0); r.mrdy = 1'($urandom);
            run(r, $urandom_range(0, 49) == 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
